// File: rtl/ram64x8_ctrl.sv
// Request/response front end for the 64x8 asynchronous SRAM: sequences
// active-low _ce/_we/_oe with programmable setup, strobe and hold phases.
module ram64x8_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adrs,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_din_en,
  output logic              _ce,
  output logic              _we,
  output logic              _oe,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  // Counters are loaded with length-1 so a phase ends on the cycle it reads zero.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_op;
  logic [ADDR_W-1:0]   r_adrs;
  logic [DATA_W-1:0]   r_din;
  logic                r_din_en;
  logic                r_ce;
  logic                r_we;
  logic                r_oe;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_op        <= 1'b0;
      r_adrs      <= '0;
      r_din       <= '0;
      r_din_en    <= 1'b0;
      r_ce        <= 1'b1;
      r_we        <= 1'b1;
      r_oe        <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state  <= S_SETUP;
            r_cnt    <= SETUP_LD;
            r_op     <= req_we;
            r_adrs   <= req_adrs;
            r_din    <= req_wdata;
            r_ce     <= 1'b0;
            r_din_en <= req_we;
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_STROBE;
            r_cnt   <= PULSE_LD;
            r_we    <= ~r_op;
            r_oe    <= r_op;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LD;
            r_we    <= 1'b1;
            r_oe    <= 1'b1;
            // _oe is still low on this edge, so ram_dout is valid here.
            if (!r_op) begin
              r_rsp_rdata <= ram_dout;
              r_rsp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_IDLE;
            r_ce     <= 1'b1;
            r_din_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign adrs       = r_adrs;
  assign ram_din    = r_din;
  assign ram_din_en = r_din_en;
  assign _ce        = r_ce;
  assign _we        = r_we;
  assign _oe        = r_oe;

endmodule

// File: tb/tb_ram64x8_ctrl.sv
// Bench for ram64x8_ctrl: default-timing instance with an SRAM model plus a
// second instance using 3/1/2 setup/pulse/hold timing.
module tb_ram64x8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [5:0] req_adrs = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, ram_din_en, ce_n, we_n, oe_n;
  logic [7:0] rsp_rdata, ram_din, ram_dout;
  logic [5:0] adrs;

  logic       b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [5:0] b_req_adrs = '0;
  logic [7:0] b_req_wdata = '0;
  logic       b_req_ready, b_rsp_valid, b_ram_din_en, b_ce_n, b_we_n, b_oe_n;
  logic [7:0] b_rsp_rdata, b_ram_din;
  logic [7:0] b_ram_dout = 8'h00;
  logic [5:0] b_adrs;

  int checks = 0;
  int errors = 0;

  ram64x8_ctrl dut_a (
    .clk(clk), ._rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .adrs(adrs), .ram_din(ram_din), .ram_din_en(ram_din_en),
    ._ce(ce_n), ._we(we_n), ._oe(oe_n), .ram_dout(ram_dout)
  );

  ram64x8_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut_b (
    .clk(clk), ._rst(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_adrs(b_req_adrs), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .adrs(b_adrs), .ram_din(b_ram_din), .ram_din_en(b_ram_din_en),
    ._ce(b_ce_n), ._we(b_we_n), ._oe(b_oe_n), .ram_dout(b_ram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model for instance A
  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  always @(posedge clk) if (!ce_n && !we_n && ram_din_en) mem[adrs] <= ram_din;
  assign ram_dout = (!ce_n && !oe_n) ? mem[adrs] : 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic inv_chk(input string nm, input logic ce, input logic we, input logic oe,
                         input logic den, input logic pce, input logic pden,
                         input logic [5:0] a, input logic [5:0] pa,
                         input logic [7:0] d, input logic [7:0] pd);
    checks++;
    if (!we && !oe) begin errors++; $display("FAIL %s_inv_we_oe: both low", nm); end
    if ((!we || !oe) && ce) begin errors++; $display("FAIL %s_inv_strobe_ce: strobe low with ce high", nm); end
    if (!pce && !ce && a !== pa) begin errors++; $display("FAIL %s_inv_adrs: got %0h expected %0h", nm, a, pa); end
    if (pden && den && d !== pd) begin errors++; $display("FAIL %s_inv_din: got %0h expected %0h", nm, d, pd); end
    if (!oe && den) begin errors++; $display("FAIL %s_inv_oe_den: din_en high with oe low", nm); end
  endtask

  logic       a_pce = 1'b1, a_pden = 1'b0, b_pce = 1'b1, b_pden = 1'b0;
  logic [5:0] a_pa = '0, b_pa = '0;
  logic [7:0] a_pd = '0, b_pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      inv_chk("A", ce_n, we_n, oe_n, ram_din_en, a_pce, a_pden, adrs, a_pa, ram_din, a_pd);
      inv_chk("B", b_ce_n, b_we_n, b_oe_n, b_ram_din_en, b_pce, b_pden, b_adrs, b_pa, b_ram_din, b_pd);
    end
    a_pce <= ce_n; a_pden <= ram_din_en; a_pa <= adrs; a_pd <= ram_din;
    b_pce <= b_ce_n; b_pden <= b_ram_din_en; b_pa <= b_adrs; b_pd <= b_ram_din;
  end

  typedef struct {
    logic       we;
    logic [5:0] a;
    logic [7:0] wd;
    logic [7:0] ce_m, we_m, oe_m, den_m, rdy_m, rsp_m;
    logic [7:0] rd;
  } vec_t;

  // One transaction on instance A; bit c of each mask is cycle c+1 after acceptance.
  task automatic txn_a(input vec_t v, input string nm);
    logic [7:0] ce_m, we_m, oe_m, den_m, rdy_m, rsp_m;
    int t;
    ce_m = '0; we_m = '0; oe_m = '0; den_m = '0; rdy_m = '0; rsp_m = '0;
    @(negedge clk);
    req_we = v.we; req_adrs = v.a; req_wdata = v.wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    check({nm, "_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_adrs = ~v.a; req_wdata = ~v.wd; req_we = ~v.we;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ce_m[c] = !ce_n; we_m[c] = !we_n; oe_m[c] = !oe_n;
      den_m[c] = ram_din_en; rdy_m[c] = !req_ready; rsp_m[c] = rsp_valid;
      if (c == 0) begin
        check({nm, "_adrs"}, 32'(adrs), 32'(v.a));
        if (v.we) check({nm, "_din"}, 32'(ram_din), 32'(v.wd));
      end
    end
    check({nm, "_ce"}, 32'(ce_m), 32'(v.ce_m));
    check({nm, "_we"}, 32'(we_m), 32'(v.we_m));
    check({nm, "_oe"}, 32'(oe_m), 32'(v.oe_m));
    check({nm, "_din_en"}, 32'(den_m), 32'(v.den_m));
    check({nm, "_ready"}, 32'(rdy_m), 32'(v.rdy_m));
    check({nm, "_rsp"}, 32'(rsp_m), 32'(v.rsp_m));
    if (!v.we) check({nm, "_rdata"}, 32'(rsp_rdata), 32'(v.rd));
  endtask

  // One transaction on instance B (3/1/2 timing); ram_dout changes after capture.
  task automatic txn_b(input logic bw, input string nm);
    logic [7:0] ce_m, st_m, den_m, rsp_m;
    ce_m = '0; st_m = '0; den_m = '0; rsp_m = '0;
    b_ram_dout = 8'h5A;
    @(negedge clk);
    check({nm, "_ready"}, 32'(b_req_ready), 32'd1);
    b_req_we = bw; b_req_adrs = 6'h2A; b_req_wdata = 8'h3C; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ce_m[c] = !b_ce_n; st_m[c] = bw ? !b_we_n : !b_oe_n;
      den_m[c] = b_ram_din_en; rsp_m[c] = b_rsp_valid;
      if (c == 4) b_ram_dout = 8'hC3;
    end
    check({nm, "_ce"}, 32'(ce_m), 32'h3F);
    check({nm, "_strobe"}, 32'(st_m), 32'h08);
    check({nm, "_din_en"}, 32'(den_m), bw ? 32'h3F : 32'h00);
    check({nm, "_rsp"}, 32'(rsp_m), bw ? 32'h00 : 32'h10);
    if (!bw) check({nm, "_rdata"}, 32'(b_rsp_rdata), 32'h5A);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl [8];
  int   acc [3];
  int   na, cyc, hi1, nrsp;
  logic [7:0] rd4;

  initial begin
    tbl[0] = '{1'b1, 6'h00, 8'hFF, 8'h0F, 8'h06, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 6'h10, 8'hEE, 8'h0F, 8'h06, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 6'h20, 8'hDD, 8'h0F, 8'h06, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 6'h30, 8'hCC, 8'h0F, 8'h06, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00};
    tbl[4] = '{1'b0, 6'h00, 8'h00, 8'h0F, 8'h00, 8'h06, 8'h00, 8'h0F, 8'h08, 8'hFF};
    tbl[5] = '{1'b0, 6'h10, 8'h00, 8'h0F, 8'h00, 8'h06, 8'h00, 8'h0F, 8'h08, 8'hEE};
    tbl[6] = '{1'b0, 6'h20, 8'h00, 8'h0F, 8'h00, 8'h06, 8'h00, 8'h0F, 8'h08, 8'hDD};
    tbl[7] = '{1'b0, 6'h30, 8'h00, 8'h0F, 8'h00, 8'h06, 8'h00, 8'h0F, 8'h08, 8'hCC};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ce", 32'(ce_n), 32'd1);
    check("rst_we", 32'(we_n), 32'd1);
    check("rst_oe", 32'(oe_n), 32'd1);
    check("rst_din_en", 32'(ram_din_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'({adrs, ram_din, rsp_rdata}), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a write strobe
    @(negedge clk);
    req_we = 1'b1; req_adrs = 6'h05; req_wdata = 8'h11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t1_we_low", 32'(we_n), 32'd0);
    check("t1_ready_low", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_ce", 32'(ce_n), 32'd1);
    check("t1_we", 32'(we_n), 32'd1);
    check("t1_oe", 32'(oe_n), 32'd1);
    check("t1_din_en", 32'(ram_din_en), 32'd0);
    check("t1_ready", 32'(req_ready), 32'd1);
    check("t1_adrs", 32'(adrs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t1_no_write", 32'(mem[5]), 32'd0);

    // Writes then reads through the table
    for (int i = 0; i < 8; i++) txn_a(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back with req_valid held high: write 3F/A5, read 3F, write 3F/5A
    na = 0; cyc = 0; hi1 = 0; nrsp = 0; rd4 = 8'h00;
    @(negedge clk);
    req_we = 1'b1; req_adrs = 6'h3F; req_wdata = 8'hA5; req_valid = 1'b1;
    while (na < 3 && cyc < 60) begin
      if (ce_n && na == 1) hi1++;
      if (rsp_valid) begin nrsp++; rd4 = rsp_rdata; end
      if (req_ready) begin
        acc[na] = cyc;
        na++;
        @(posedge clk); #1;
        req_we = ~req_we;
        req_wdata = 8'h5A;
        if (na == 3) req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("t4_accepts", 32'(na), 32'd3);
    check("t4_gap01", 32'(acc[1] - acc[0]), 32'd5);
    check("t4_gap12", 32'(acc[2] - acc[1]), 32'd5);
    check("t4_ce_high", 32'(hi1), 32'd1);
    check("t4_nrsp", 32'(nrsp), 32'd1);
    check("t4_rdata", 32'(rd4), 32'hA5);
    repeat (6) @(negedge clk);
    check("t4_mem", 32'(mem[63]), 32'h5A);
    check("t4_rdata_held", 32'(rsp_rdata), 32'hA5);

    // Non-default timing on instance B
    txn_b(1'b1, "t5_wr");
    txn_b(1'b0, "t5_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
